// File: rtl/shot_clock_display_drv.sv
// Two-digit multiplexed 7-segment driver with alarm blink and timed buzzer tone.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module shot_clock_display_drv #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLINK_DIV     = 12500000,
    parameter int unsigned BUZZ_CYCLES   = 50000000,
    parameter int unsigned BUZZ_TONE_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] timesh,
    input  logic [3:0] timesl,
    input  logic       alarm,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       buzzer
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1)     ? $clog2(BLINK_DIV)     : 1;
    localparam int unsigned DUR_W   = (BUZZ_CYCLES > 1)   ? $clog2(BUZZ_CYCLES)   : 1;
    localparam int unsigned TONE_W  = (BUZZ_TONE_DIV > 1) ? $clog2(BUZZ_TONE_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [DUR_W-1:0]   DUR_LAST   = DUR_W'(BUZZ_CYCLES - 1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(BUZZ_TONE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOUND = 2'd1,
        ST_HOLD  = 2'd2
    } buzz_state_e;

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [3:0]         th_q, tl_q;
    logic               al_q, al_prev_q;
    logic               al_rise_s;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               sel_q, sel_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blank_q, blank_d;
    buzz_state_e        state_q, state_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic               dur_done_s, tone_done_s;
    logic [3:0]         digit_s;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         dig_en_q, dig_en_d;
    logic               buzzer_q, buzzer_d;

    // Input capture plus one-cycle alarm history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th_q      <= 4'd0;
            tl_q      <= 4'd0;
            al_q      <= 1'b0;
            al_prev_q <= 1'b0;
        end else begin
            th_q      <= timesh;
            tl_q      <= timesl;
            al_q      <= alarm;
            al_prev_q <= al_q;
        end
    end

    assign al_rise_s   = al_q & ~al_prev_q;
    assign dur_done_s  = (dur_cnt_q == DUR_LAST);
    assign tone_done_s = (tone_cnt_q == TONE_LAST);

    // Digit scan divider; sel flips on every wrap
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        sel_d      = sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            sel_d      = ~sel_q;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            sel_d      = sel_q;
        end
    end

    // Blink divider; a fresh alarm edge restarts it so the first phase is visible
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if (!al_q) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (al_rise_s) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blank_d     = blank_q;
        end
    end

    // Scan and blink state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            sel_q       <= 1'b0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            sel_q       <= sel_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    // Buzzer FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buzzer FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (al_rise_s) begin
                    state_d = ST_SOUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SOUND: begin
                if (!al_q) begin
                    state_d = ST_IDLE;
                end else if (dur_done_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SOUND;
                end
            end
            ST_HOLD: begin
                if (!al_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buzzer FSM outputs: tone/duration counters and next buzzer level
    always_comb begin
        buzzer_d   = 1'b0;
        dur_cnt_d  = '0;
        tone_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (al_rise_s) begin
                    buzzer_d = 1'b1;
                end else begin
                    buzzer_d = 1'b0;
                end
            end
            ST_SOUND: begin
                if (al_q && !dur_done_s) begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    if (tone_done_s) begin
                        tone_cnt_d = '0;
                        buzzer_d   = ~buzzer_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + TONE_W'(1);
                        buzzer_d   = buzzer_q;
                    end
                end else begin
                    buzzer_d = 1'b0;
                end
            end
            ST_HOLD: buzzer_d = 1'b0;
            default: buzzer_d = 1'b0;
        endcase
    end

    // Tone and duration counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
        end else begin
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
        end
    end

    // Output selection; blanking follows blank_d so it lines up with the buzzer edge
    always_comb begin
        digit_s  = sel_q ? th_q : tl_q;
        dig_en_d = sel_q ? 2'b10 : 2'b01;
        if (blank_d) begin
            seg_d = 7'h00;
        end else begin
            seg_d = seg7_decode(digit_s);
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_q && (th_q == 4'd0)) begin
            seg_d = 7'h00;
        end else begin
            seg_d = seg_d;
        end
`endif
    end

    // Registered display and buzzer outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= 7'h00;
            dig_en_q <= 2'b00;
            buzzer_q <= 1'b0;
        end else begin
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign seg    = seg_q;
    assign dig_en = dig_en_q;
    assign buzzer = buzzer_q;

endmodule

// File: tb/tb_shot_clock_display_drv.sv
// Scoreboard bench for shot_clock_display_drv: expectations are queued per clock edge
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_shot_clock_display_drv;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'h00;
`else
    localparam logic [6:0] TZ = 7'h3F;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] timesh;
    logic [3:0] timesl;
    logic       alarm;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       buzzer;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic [1:0] dig;
        logic       buz;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    shot_clock_display_drv #(
        .SCAN_DIV     (4),
        .BLINK_DIV    (8),
        .BUZZ_CYCLES  (20),
        .BUZZ_TONE_DIV(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .timesh(timesh),
        .timesl(timesl),
        .alarm (alarm),
        .seg   (seg),
        .dig_en(dig_en),
        .buzzer(buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e  = sb_q.pop_front();
            checks = checks + 1;
            if (mon_e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s entry for cycle %0d was not checked until cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (seg !== mon_e.seg || dig_en !== mon_e.dig || buzzer !== mon_e.buz) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d got seg=%h dig_en=%b buzzer=%b expected seg=%h dig_en=%b buzzer=%b",
                         mon_e.name, cyc, seg, dig_en, buzzer, mon_e.seg, mon_e.dig, mon_e.buz);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input int e, input logic [6:0] s, input logic [1:0] d,
                        input logic b, input string n);
        exp_t x;
        x.cyc  = e;
        x.seg  = s;
        x.dig  = d;
        x.buz  = b;
        x.name = n;
        sb_q.push_back(x);
    endtask

    // r: last edge with rst high; bs/be: blink window; zs/ze: buzzer sounding window
    task automatic expect_range(input int e0, input int e1, input int r,
                                input int bs, input int be,
                                input logic [6:0] up, input logic [6:0] tp,
                                input int zs, input int ze, input string n);
        for (int e = e0; e <= e1; e++) begin
            logic       tens;
            logic       vis;
            logic [6:0] s;
            logic       b;
            tens = ((((e - (r + 1)) / 4) % 2) == 1);
            vis  = (e < bs) || (e >= be) || ((((e - bs) / 8) % 2) == 0);
            s    = !vis ? 7'h00 : (tens ? tp : up);
            b    = (e >= zs && e < ze) ? ((((e - zs) / 2) % 2) == 0) : 1'b0;
            push(e, s, tens ? 2'b10 : 2'b01, b, n);
        end
    endtask

    initial begin
        rst    = 1'b1;
        timesh = 4'd2;
        timesl = 4'd4;
        alarm  = 1'b0;

        tick(1);
        push(1, 7'h00, 2'b00, 1'b0, "reset_state");
        push(2, 7'h00, 2'b00, 1'b0, "reset_state");
        tick(1);
        rst = 1'b0;
        push(3, 7'h3F, 2'b01, 1'b0, "first_edge");
        expect_range(4, 18, 2, 0, 0, 7'h66, 7'h5B, 0, 0, "scan_24");

        goto_cyc(18);
        for (int v = 0; v < 16; v++) begin
            timesl = 4'(v);
            push(21 + 8 * v, pat_tbl[v], 2'b01, 1'b0, "decode_units");
            tick(8);
        end

        timesh = 4'd0;
        timesl = 4'd0;
        goto_cyc(150);
        alarm = 1'b1;
        expect_range(151, 207, 2, 152, 202, 7'h3F, TZ, 152, 172, "alarm_blink_tone");
        goto_cyc(200);
        alarm = 1'b0;

        goto_cyc(208);
        alarm = 1'b1;
        expect_range(209, 225, 2, 210, 216, 7'h3F, TZ, 210, 216, "early_drop");
        goto_cyc(214);
        alarm = 1'b0;

        goto_cyc(226);
        alarm = 1'b1;
        expect_range(227, 231, 2, 228, 1000, 7'h3F, TZ, 228, 1000, "sound_pre_rst");
        push(232, 7'h00, 2'b00, 1'b0, "async_rst");
        push(233, 7'h00, 2'b00, 1'b0, "rst_hold");
        push(234, 7'h00, 2'b00, 1'b0, "rst_hold");
        goto_cyc(232);
        rst = 1'b1;
        goto_cyc(234);
        rst = 1'b0;
        expect_range(235, 260, 234, 236, 1000, 7'h3F, TZ, 236, 256, "retrigger");

        goto_cyc(262);
        alarm  = 1'b0;
        timesl = 4'd7;
        expect_range(266, 274, 234, 0, 0, 7'h07, TZ, 0, 0, "lead_zero");

        goto_cyc(280);
        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_clock_display_drv.md
# shot_clock_display_drv

Output stage that sits directly downstream of the 24-second shot-clock counter. It consumes the counter's BCD tens/units digits and alarm flag and drives a time-multiplexed two-digit 7-segment display and a piezo buzzer. It adds digit scanning, an alarm blink, and a timed buzzer tone, so the counter core stays free of board-level display concerns.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot (scan period is 2×SCAN_DIV).
- `BLINK_DIV`, default 12500000: clk cycles per blink half-period while alarm is high.
- `BUZZ_CYCLES`, default 50000000: buzzer sounding duration in clk cycles.
- `BUZZ_TONE_DIV`, default 12500: clk cycles per buzzer output half-period.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `timesh`  in  4  tens digit (BCD) from the counter.
- `timesl`  in  4  units digit (BCD) from the counter.
- `alarm`  in  1  level alarm flag from the counter (high while time has expired).
- `seg`  out  7  segment drive, active-high, `{g,f,e,d,c,b,a}`, bit 0 = a.
- `dig_en`  out  2  one-hot digit enable, active-high; bit 0 = units, bit 1 = tens.
- `buzzer`  out  1  square-wave buzzer drive.

## Operation
- **Input register.** `timesh`, `timesl` and `alarm` are registered every cycle into `th_q`, `tl_q` and `al_q`. `al_rise = al_q & ~al_q_d` marks the alarm rising edge.
- **Scan.** `scan_cnt` counts 0..SCAN_DIV-1 and wraps. On wrap, `sel` toggles. `sel=0` shows units (`tl_q`, `dig_en=01`); `sel=1` shows tens (`th_q`, `dig_en=10`).
- **Decode.**
  - 0..9 use the standard patterns: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
  - 10..15 display a dash, 7'h40.
- **Blink.**
  - While `al_q=1`, `blink_cnt` counts 0..BLINK_DIV-1 and toggles `blank` on each wrap.
  - `al_rise` clears `blink_cnt` and `blank`, so the first phase is visible.
  - While `al_q=0`, `blank=0` and the counter is held at 0.
  - `blank=1` forces `seg=0`; `dig_en` keeps scanning.
- **Buzzer FSM.**
  - States are IDLE, SOUND and HOLD.
  - IDLE → SOUND on `al_rise`; `dur_cnt` and `tone_cnt` clear and `buzzer` starts at 1.
  - In SOUND, `buzzer` toggles every BUZZ_TONE_DIV cycles.
  - SOUND → HOLD after BUZZ_CYCLES cycles in SOUND; `buzzer` goes to 0.
  - SOUND → IDLE if `al_q` falls before the duration elapses; `buzzer` goes to 0 on the same edge.
  - HOLD → IDLE when `al_q=0`. No re-trigger without a new rising edge.
  - `buzzer=0` in IDLE and HOLD.
- **Simultaneous events.** `al_rise` takes priority over the counter wrap in the blink logic. A new `al_rise` can only occur from IDLE.
- **Reset.** `rst` asserted at any time, including mid-SOUND, immediately yields:
  - `seg=0`, `dig_en=00`, `buzzer=0`;
  - FSM in IDLE;
  - all counters 0, `sel=0`, `blank=0`;
  - `al_q=0`, so an alarm already high at release produces a rising edge.

## Timing
- All outputs are registered. Reset values: `seg=7'h00`, `dig_en=2'b00`, `buzzer=0`.
- First edge after `rst` deasserts: `dig_en=01`, `seg` shows the decoded `tl_q` (0 → 7'h3F).
- **Display latency.** An input digit change appears on `seg` 2 cycles later when its digit is selected: 1 cycle input register, 1 cycle output register.
- **Alarm latency.**
  - Rise on `alarm` in cycle n: `buzzer=1` at edge n+2.
  - First blank phase starts after BLINK_DIV further cycles.
- **Scan timing.** Each digit is enabled for exactly SCAN_DIV cycles. `dig_en` changes on the same edge as `seg`, so there are no mixed-digit cycles.

## Configuration
- **`LEADING_ZERO_BLANK_EN`**
  - Defined: when `sel=1` and `th_q==0`, `seg=0` (tens blank, so "5" instead of "05"); `dig_en` is unchanged.
  - Undefined: the tens digit always displays, including 0 (7'h3F).

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=8, BUZZ_CYCLES=20, BUZZ_TONE_DIV=2.
- **Reset/scan:** `rst` high, then low with `timesh=2`, `timesl=4` →
  - `seg=0`, `dig_en=00` during reset;
  - then `dig_en` alternates 01/10 every 4 cycles;
  - `seg=7'h66` with 01, `seg=7'h5B` with 10.
- **Decode sweep:** `timesl` 0..15 →
  - correct patterns for 0..9;
  - 7'h40 for 10..15.
- **Alarm:** `alarm` rises with digits 0/0 →
  - `buzzer` toggles every 2 cycles for 20 cycles, then stays 0 while `alarm` is held;
  - `seg` visible 8 cycles, blank 8, visible 8, and so on.
- **Early alarm drop:** `alarm` high for 6 cycles → `buzzer` returns to 0 one cycle after `al_q` falls.
- **Reset mid-SOUND:** assert `rst` 5 cycles into SOUND →
  - `buzzer=0` immediately (asynchronous);
  - after release with `alarm` still high, a new 20-cycle tone plays.
- **Macro:** with `LEADING_ZERO_BLANK_EN` and `timesh=0`, `timesl=7` →
  - tens slot `seg=0`;
  - units `seg=7'h07`.
